mips_cpu_bus_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single Avalon memory-mapped bus between the instruction-fetch requester and the load/store data requester. It serialises their transfers, holds bus signals stable across `waitrequest` stalls, returns read data and a one-cycle acknowledge to the owning port, and aborts transfers that stall beyond a programmable watchdog limit. It sits between the multi-cycle controller/datapath and the external memory bus.

---
 rtl/mips_cpu_bus_arbiter_if.sv | 44 ++++
 rtl/mips_cpu_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Signal bundle joining the bus arbiter to its fetch/data requesters and the Avalon memory bus.
// master: the arbiter's view; slave: the requesters' and memory's view.
interface mips_cpu_bus_arbiter_if;
    // Fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    // Load/store requester
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    // Status
    logic        bus_err;
    logic        busy;
    // Avalon memory-mapped master
    logic [31:0] mem_address;
    logic        memread;
    logic        memwrite;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] memreaddata;

    // Handshake: a requester holds its request and payload stable until it sees its
    // one-cycle ack; the arbiter holds every Avalon output stable while waitrequest is high.
    modport master (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
        input  waitrequest, memreaddata,
        output i_ack, i_rdata, d_ack, d_rdata, bus_err, busy,
        output mem_address, memread, memwrite, memwritedata, byteenable
    );

    modport slave (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
        output waitrequest, memreaddata,
        input  i_ack, i_rdata, d_ack, d_rdata, bus_err, busy,
        input  mem_address, memread, memwrite, memwritedata, byteenable
    );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon bus between instruction fetch and load/store, with round-robin
// tie-breaking and a waitrequest watchdog that aborts stalled transfers.
module mips_cpu_bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_bus_arbiter_if.master        bus,
    output logic [1:0]                    dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          OWN_FETCH = 1'b0;
    localparam logic          OWN_DATA  = 1'b1;

    state_t        state;
    logic          own;
    logic          last;
    logic [CW-1:0] wd_cnt;

    logic [31:0]   mem_address_r;
    logic          memread_r;
    logic          memwrite_r;
    logic [31:0]   memwritedata_r;
    logic [3:0]    byteenable_r;
    logic          i_ack_r;
    logic          d_ack_r;
    logic [31:0]   i_rdata_r;
    logic [31:0]   d_rdata_r;
    logic          bus_err_r;
    logic          busy_r;

    logic          i_pend;
    logic          d_pend;
    logic          grant_data;
    logic          timeout_hit;

    always_comb begin
        i_pend      = bus.i_req;
        d_pend      = bus.d_read | bus.d_write;
        // On a tie the port that did not win last time gets the bus.
        grant_data  = d_pend & (~i_pend | (last == OWN_FETCH));
        // Firing when the count is one short means strobes last exactly TIMEOUT cycles.
        timeout_hit = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            own            <= OWN_FETCH;
            last           <= OWN_DATA;
            wd_cnt         <= '0;
            mem_address_r  <= '0;
            memread_r      <= 1'b0;
            memwrite_r     <= 1'b0;
            memwritedata_r <= '0;
            byteenable_r   <= '0;
            i_ack_r        <= 1'b0;
            d_ack_r        <= 1'b0;
            i_rdata_r      <= '0;
            d_rdata_r      <= '0;
            bus_err_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_pend | d_pend) begin
                        state  <= BUSY;
                        own    <= grant_data;
                        last   <= grant_data;
                        busy_r <= 1'b1;
                        wd_cnt <= '0;
                        if (grant_data) begin
                            mem_address_r  <= bus.d_addr;
                            memwritedata_r <= bus.d_wdata;
                            byteenable_r   <= bus.d_byteenable;
                            memwrite_r     <= bus.d_write;
                            memread_r      <= ~bus.d_write;
                        end else begin
                            mem_address_r  <= bus.i_addr;
                            memwritedata_r <= '0;
                            byteenable_r   <= 4'b1111;
                            memwrite_r     <= 1'b0;
                            memread_r      <= 1'b1;
                        end
                    end
                end

                BUSY: begin
                    if (!bus.waitrequest || timeout_hit) begin
                        if (!bus.waitrequest) begin
                            if (memread_r) begin
                                if (own == OWN_DATA) d_rdata_r <= bus.memreaddata;
                                else                 i_rdata_r <= bus.memreaddata;
                            end
                        end else begin
                            if (own == OWN_DATA) d_rdata_r <= '0;
                            else                 i_rdata_r <= '0;
                        end
                        bus_err_r  <= bus.waitrequest;
                        memread_r  <= 1'b0;
                        memwrite_r <= 1'b0;
                        busy_r     <= 1'b0;
                        i_ack_r    <= (own == OWN_FETCH);
                        d_ack_r    <= (own == OWN_DATA);
                        state      <= ACK;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                ACK: begin
                    i_ack_r   <= 1'b0;
                    d_ack_r   <= 1'b0;
                    bus_err_r <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_address  = mem_address_r;
    assign bus.memread      = memread_r;
    assign bus.memwrite     = memwrite_r;
    assign bus.memwritedata = memwritedata_r;
    assign bus.byteenable   = byteenable_r;
    assign bus.i_ack        = i_ack_r;
    assign bus.d_ack        = d_ack_r;
    assign bus.i_rdata      = i_rdata_r;
    assign bus.d_rdata      = d_rdata_r;
    assign bus.bus_err      = bus_err_r;
    assign bus.busy         = busy_r;
    assign dbg_state        = state;
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed scenarios plus randomized concurrent traffic,
// checked by a monitor against a rule-level model of arbitration and completion.
module tb_mips_cpu_bus_arbiter;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter_if bus ();

  mips_cpu_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] i_exp_q[$];   // {bus_err, rdata}
  logic [32:0] d_exp_q[$];
  logic        grant_log[$]; // 0 = fetch, 1 = data
  logic [31:0] d_last_rdata;

  // memory responder controls
  int wr_mode;      // 0 random stall, 1 fixed stall, 2 stuck
  int fixed_stall;
  int xfer_stall;
  int stall_left;
  bit armed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pattern memory: read data is a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the ack, request low.
  task automatic fetch_txn(input logic [31:0] addr, input int exp_lat);
    int cyc = 0;
    i_exp_q.push_back({1'b0, mem_fn(addr)});
    bus.i_addr = addr;
    bus.i_req  = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.i_ack || cyc > 200) break;
      cyc++;
    end
    chk("fetch_ack_seen", 64'(bus.i_ack), 64'(1));
    if (exp_lat >= 0) chk("fetch_latency", 64'(cyc), 64'(exp_lat));
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic data_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          input logic rd, input logic wr, input int exp_lat, input logic exp_to);
    int cyc = 0;
    logic [31:0] er;
    if (exp_to)  er = 32'h0;
    else if (wr) er = d_last_rdata;
    else         er = mem_fn(addr);
    d_last_rdata = er;
    d_exp_q.push_back({exp_to, er});
    bus.d_addr       = addr;
    bus.d_wdata      = wdata;
    bus.d_byteenable = be;
    bus.d_read       = rd;
    bus.d_write      = wr;
    while (1) begin
      @(negedge clk);
      if (bus.d_ack || cyc > 200) break;
      cyc++;
    end
    chk("data_ack_seen", 64'(bus.d_ack), 64'(1));
    if (exp_lat >= 0) chk("data_latency", 64'(cyc), 64'(exp_lat));
    @(posedge clk); #1;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic idle_gap(input int g);
    repeat (g) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fetch_loop(input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      fetch_txn(a, -1);
      idle_gap($urandom_range(0, 3));
    end
  endtask

  task automatic data_loop(input int n);
    int kind;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 2);
      data_txn($urandom, $urandom, 4'($urandom_range(0, 15)),
               kind != 1, kind != 0, -1, 1'b0);
      idle_gap($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_last_rdata = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bus.waitrequest = 1'b0;
    bus.memreaddata = 32'h0;
    armed = 1'b0;
    xfer_stall = 0;
    stall_left = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.memread || bus.memwrite) begin
        if (!armed) begin
          armed = 1'b1;
          if (wr_mode == 0)      xfer_stall = $urandom_range(0, 3);
          else if (wr_mode == 1) xfer_stall = fixed_stall;
          else                   xfer_stall = TO - 1;
          stall_left = xfer_stall;
        end
        if (wr_mode == 2) begin
          bus.waitrequest = 1'b1;
        end else if (stall_left > 0) begin
          bus.waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.waitrequest = 1'b0;
        end
        bus.memreaddata = mem_fn(bus.mem_address);
      end else begin
        armed = 1'b0;
        bus.waitrequest = 1'($urandom_range(0, 1));
        bus.memreaddata = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_strobe = 1'b0;
  logic        m_last = 1'b1;
  logic        owner = 1'b0;
  int          xlen = 0;
  logic        p_i = 1'b0, p_d = 1'b0, p_dwr = 1'b0;
  logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0;
  logic [3:0]  p_dbe = '0;
  logic [37:0] cur_bus;
  logic [31:0] cur_wd;
  logic [1:0]  cur_state;

  initial begin
    logic strobe, win, e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      strobe = bus.memread | bus.memwrite;
      if (reset) begin
        chk("reset_ctrl", 64'({bus.i_ack, bus.d_ack, bus.bus_err, bus.busy, bus.memread,
                                bus.memwrite, bus.byteenable}), 64'(0));
        chk("reset_bus", {bus.mem_address, bus.memwritedata}, 64'(0));
        chk("reset_rdata", {bus.i_rdata, bus.d_rdata}, 64'(0));
        m_last = 1'b1;
        prev_strobe = 1'b0;
        xlen = 0;
      end else begin
        chk("busy_eq_strobe", 64'(bus.busy), 64'(strobe));
        chk("ack_timing", 64'(bus.i_ack | bus.d_ack), 64'(prev_strobe & ~strobe));
        chk("ack_exclusive", 64'(bus.i_ack & bus.d_ack), 64'(0));
        chk("err_only_with_ack", 64'(bus.bus_err & ~(bus.i_ack | bus.d_ack)), 64'(0));
        if (strobe && !prev_strobe) begin
          chk("grant_has_request", 64'(p_i | p_d), 64'(1));
          win    = (p_i && p_d) ? ~m_last : ~p_i;
          e_addr = win ? p_daddr : p_iaddr;
          e_wr   = win ? p_dwr : 1'b0;
          e_be   = win ? p_dbe : 4'b1111;
          chk("grant_addr", 64'(bus.mem_address), 64'(e_addr));
          chk("grant_dir", 64'({bus.memread, bus.memwrite}), 64'({~e_wr, e_wr}));
          chk("grant_be", 64'(bus.byteenable), 64'(e_be));
          if (!win || e_wr) chk("grant_wdata", 64'(bus.memwritedata), 64'(win ? p_dwdata : 32'h0));
          m_last    = win;
          owner     = win;
          xlen      = 1;
          cur_bus   = {bus.mem_address, bus.memread, bus.memwrite, bus.byteenable};
          cur_wd    = bus.memwritedata;
          cur_state = dbg_state;
          grant_log.push_back(win);
        end else if (strobe) begin
          chk("hold_bus", 64'({bus.mem_address, bus.memread, bus.memwrite, bus.byteenable}), 64'(cur_bus));
          chk("hold_wdata", 64'(bus.memwritedata), 64'(cur_wd));
          chk("hold_state", 64'(dbg_state), 64'(cur_state));
          xlen++;
        end
        if (!strobe && prev_strobe) chk("strobe_len", 64'(xlen), 64'(xfer_stall + 1));
        if (bus.i_ack) begin
          chk("i_ack_owner", 64'(owner), 64'(0));
          chk("i_exp_q_nonempty", 64'(i_exp_q.size() != 0), 64'(1));
          if (i_exp_q.size() != 0) begin
            e = i_exp_q.pop_front();
            chk("i_result", 64'({bus.bus_err, bus.i_rdata}), 64'(e));
          end
        end
        if (bus.d_ack) begin
          chk("d_ack_owner", 64'(owner), 64'(1));
          chk("d_exp_q_nonempty", 64'(d_exp_q.size() != 0), 64'(1));
          if (d_exp_q.size() != 0) begin
            e = d_exp_q.pop_front();
            chk("d_result", 64'({bus.bus_err, bus.d_rdata}), 64'(e));
          end
        end
        prev_strobe = strobe;
      end
      p_i      = bus.i_req;
      p_d      = bus.d_read | bus.d_write;
      p_iaddr  = bus.i_addr;
      p_daddr  = bus.d_addr;
      p_dwdata = bus.d_wdata;
      p_dbe    = bus.d_byteenable;
      p_dwr    = bus.d_write;
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #500000;
    $display("FAIL global_time_limit: run did not finish, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int mark, w;
    bus.i_req = 1'b0;
    bus.i_addr = 32'h0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_byteenable = 4'h0;
    wr_mode = 1;
    fixed_stall = 0;
    d_last_rdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single fetch, no stall
    fetch_txn(32'hBFC0_0000, 2);

    // data write with three stall cycles
    fixed_stall = 3;
    data_txn(32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1, 5, 1'b0);

    // simultaneous requests after reset alternate
    fixed_stall = 0;
    do_reset();
    mark = grant_log.size();
    fork
      begin
        fetch_txn(32'h0040_0000, -1);
        fetch_txn(32'h0040_0004, -1);
      end
      begin
        data_txn(32'h1000_0010, 32'h0, 4'hF, 1'b1, 1'b0, -1, 1'b0);
        data_txn(32'h1000_0014, 32'h0, 4'hF, 1'b1, 1'b0, -1, 1'b0);
      end
    join
    chk("alt_grant_count", 64'(grant_log.size()), 64'(mark + 4));
    for (int k = 0; k < 4; k++) chk("alt_order", 64'(grant_log[mark + k]), 64'(k % 2));

    // watchdog abort on a stuck data read, then a clean fetch
    wr_mode = 2;
    data_txn(32'h2000_0000, 32'h0, 4'hF, 1'b1, 1'b0, TO + 1, 1'b1);
    wr_mode = 1;
    fetch_txn(32'h0040_0008, 2);

    // reset in the second stall cycle of a fetch; the held request restarts afterwards
    wr_mode = 2;
    fork
      fetch_txn(32'h0040_0100, -1);
      begin
        w = 0;
        while (!bus.memread && w < 50) begin
          @(negedge clk);
          w++;
        end
        chk("reset_test_strobe_seen", 64'(bus.memread), 64'(1));
        @(posedge clk); #2;
        reset = 1'b1;
        d_last_rdata = 32'h0;
        #1;
        chk("reset_async_drop", 64'({bus.memread, bus.busy, bus.i_ack}), 64'(0));
        wr_mode = 1;
        fixed_stall = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    join

    // read and write both set: write wins
    data_txn(32'h0000_2000, 32'hCAFE_F00D, 4'b1100, 1'b1, 1'b1, 2, 1'b0);

    // randomized concurrent traffic
    wr_mode = 0;
    fork
      fetch_loop(60);
      data_loop(60);
    join

    repeat (4) @(negedge clk);
    chk("i_exp_q_drained", 64'(i_exp_q.size()), 64'(0));
    chk("d_exp_q_drained", 64'(d_exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
